// File: rtl/pc_seq_ctrl.sv
// PC sequencing control: picks the next-PC source (trap, branch, jump, increment)
// and generates bubble/flush controls for load-use, instruction-memory and trap-drain stalls.
module pc_seq_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080,
  parameter int          LU_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        trap_req,
  input  logic        ld_use,
  input  logic        imem_ready,
  output logic        PCnewEnable,
  output logic [31:0] PCnew,
  output logic        bubble,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] epc,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {RUN, LU_WAIT, IMEM_WAIT, TRAP_DRAIN} state_t;

  localparam logic [2:0] LU_LOAD = 3'(LU_STALL - 1);

  state_t     state, state_nx;
  logic [2:0] lu_cnt, lu_cnt_nx;
  logic [1:0] drain_cnt, drain_cnt_nx;
  logic       trap_acc;

  assign dbg_state = state;

  // Outputs are a pure decode of state and inputs; everything is forced low in reset.
  always_comb begin
    PCnewEnable  = 1'b0;
    PCnew        = 32'h0;
    bubble       = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    trap_acc     = 1'b0;
    state_nx     = state;
    lu_cnt_nx    = lu_cnt;
    drain_cnt_nx = drain_cnt;
    if (rst) begin
      if (state == TRAP_DRAIN) begin
        flush_id = 1'b1;
        bubble   = !imem_ready;
        if (imem_ready) begin
          drain_cnt_nx = drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state_nx = RUN;
        end
      end else if (trap_req) begin
        PCnewEnable  = 1'b1;
        PCnew        = TRAP_VEC;
        flush_if     = 1'b1;
        flush_id     = 1'b1;
        trap_acc     = 1'b1;
        state_nx     = TRAP_DRAIN;
        drain_cnt_nx = 2'd2;
        lu_cnt_nx    = 3'd0;
      end else if (br_taken) begin
        PCnewEnable = 1'b1;
        PCnew       = br_target;
        flush_if    = 1'b1;
        flush_id    = 1'b1;
        state_nx    = RUN;
        lu_cnt_nx   = 3'd0;
      end else begin
        case (state)
          LU_WAIT: begin
            bubble    = 1'b1;
            flush_id  = 1'b1;
            lu_cnt_nx = lu_cnt - 3'd1;
            if (lu_cnt == 3'd1) state_nx = RUN;
          end
          IMEM_WAIT: begin
            // The fetch slot stays squashed until memory answers.
            if (!imem_ready) begin
              bubble   = 1'b1;
              flush_if = 1'b1;
            end else begin
              state_nx = RUN;
            end
          end
          default: begin
            if (jmp_valid) begin
              PCnewEnable = 1'b1;
              PCnew       = jmp_target;
              flush_if    = 1'b1;
            end else if (ld_use) begin
              bubble   = 1'b1;
              flush_id = 1'b1;
              if (LU_STALL > 1) begin
                lu_cnt_nx = LU_LOAD;
                state_nx  = LU_WAIT;
              end
            end else if (!imem_ready) begin
              bubble   = 1'b1;
              flush_if = 1'b1;
              state_nx = IMEM_WAIT;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      lu_cnt    <= 3'd0;
      drain_cnt <= 2'd0;
      epc       <= 32'h0;
      stall_cnt <= 16'h0;
    end else begin
      state     <= state_nx;
      lu_cnt    <= lu_cnt_nx;
      drain_cnt <= drain_cnt_nx;
      if (trap_acc) epc <= pc_in;
      if (bubble && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of pending-stall bookkeeping.
module tb_pc_seq_ctrl;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;
  localparam int          LU_STALL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, br_target, jmp_target;
  logic        br_taken, jmp_valid, trap_req, ld_use, imem_ready;
  logic        PCnewEnable, bubble, flush_if, flush_id;
  logic [31:0] PCnew, epc;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Model state: remaining load-use bubbles, imem-wait flag, remaining drain slots.
  int          lu_left = 0;
  bit          imem_wait = 0;
  int          drain_left = 0;
  logic [31:0] epc_m = 32'h0;
  int          stall_m = 0;

  logic        e_pcen, e_bub, e_fif, e_fid;
  logic [31:0] e_pcnew;
  int          bubbles_seen;

  pc_seq_ctrl #(.TRAP_VEC(TRAP_VEC), .LU_STALL(LU_STALL)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .trap_req(trap_req), .ld_use(ld_use),
    .imem_ready(imem_ready), .PCnewEnable(PCnewEnable), .PCnew(PCnew), .bubble(bubble),
    .flush_if(flush_if), .flush_id(flush_id), .epc(epc), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    br_taken = 0; jmp_valid = 0; trap_req = 0; ld_use = 0; imem_ready = 1;
    pc_in = 32'h0; br_target = 32'h0; jmp_target = 32'h0;
  endtask

  // Expected combinational outputs for the current inputs, from the priority rules.
  task automatic model_outputs();
    e_pcen = 0; e_pcnew = 32'h0; e_bub = 0; e_fif = 0; e_fid = 0;
    if (rst) begin
      if (drain_left > 0) begin
        e_fid = 1; e_bub = !imem_ready;
      end else if (trap_req) begin
        e_pcen = 1; e_pcnew = TRAP_VEC; e_fif = 1; e_fid = 1;
      end else if (br_taken) begin
        e_pcen = 1; e_pcnew = br_target; e_fif = 1; e_fid = 1;
      end else if (lu_left > 0) begin
        e_bub = 1; e_fid = 1;
      end else if (imem_wait) begin
        if (!imem_ready) begin e_bub = 1; e_fif = 1; end
      end else if (jmp_valid) begin
        e_pcen = 1; e_pcnew = jmp_target; e_fif = 1;
      end else if (ld_use) begin
        e_bub = 1; e_fid = 1;
      end else if (!imem_ready) begin
        e_bub = 1; e_fif = 1;
      end
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      lu_left = 0; imem_wait = 0; drain_left = 0; epc_m = 32'h0; stall_m = 0;
    end else begin
      if (e_bub && stall_m < 65535) stall_m++;
      if (drain_left > 0) begin
        if (imem_ready) drain_left--;
      end else if (trap_req) begin
        epc_m = pc_in; drain_left = 2; lu_left = 0; imem_wait = 0;
      end else if (br_taken) begin
        lu_left = 0; imem_wait = 0;
      end else if (lu_left > 0) begin
        lu_left--;
      end else if (imem_wait) begin
        if (imem_ready) imem_wait = 0;
      end else if (jmp_valid) begin
        // redirect only
      end else if (ld_use) begin
        lu_left = LU_STALL - 1;
      end else if (!imem_ready) begin
        imem_wait = 1;
      end
    end
  endtask

  // One cycle: inputs already driven after negedge; check, clock, advance model.
  task automatic step();
    #1;
    model_outputs();
    chk("pcnew_en", 32'(PCnewEnable), 32'(e_pcen));
    chk("pcnew", PCnew, e_pcnew);
    chk("bubble", 32'(bubble), 32'(e_bub));
    chk("flush_if", 32'(flush_if), 32'(e_fif));
    chk("flush_id", 32'(flush_id), 32'(e_fid));
    chk("epc", epc, epc_m);
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    if (bubble) bubbles_seen++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(negedge clk);
    repeat (2) step();

    // Idle after reset release
    rst = 1;
    bubbles_seen = 0;
    repeat (4) step();
    chk("idle_bubbles", 32'(bubbles_seen), 32'd0);
    chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use pulse: three bubble cycles total
    bubbles_seen = 0;
    ld_use = 1; step(); ld_use = 0;
    repeat (4) step();
    chk("lu_bubbles", 32'(bubbles_seen), 32'd3);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd3);

    // Branch beats jump in the same cycle
    br_taken = 1; br_target = 32'h100; jmp_valid = 1; jmp_target = 32'h200;
    #1;
    chk("br_over_jmp_pcnew", PCnew, 32'h100);
    chk("br_over_jmp_flush", {30'h0, flush_if, flush_id}, 32'h3);
    step();
    idle_inputs();

    // Trap then branch during drain
    pc_in = 32'h44; trap_req = 1;
    #1;
    chk("trap_pcnew", PCnew, 32'h80);
    step();
    trap_req = 0; br_taken = 1; br_target = 32'h300;
    #1;
    chk("drain_br_ignored", 32'(PCnewEnable), 32'd0);
    chk("drain_epc", epc, 32'h44);
    step();
    br_taken = 0;
    step();
    chk("drain_done_flush_id", 32'(flush_id), 32'd0);
    step();

    // Reset mid load-use stall aborts pending bubbles
    ld_use = 1; step(); ld_use = 0;
    rst = 0; step(); rst = 1;
    #1;
    chk("post_reset_bubble", 32'(bubble), 32'd0);
    step();

    // imem stall with branch on the third low cycle
    imem_ready = 0;
    step(); step();
    br_taken = 1; br_target = 32'h400;
    #1;
    chk("imem_br_bubble", 32'(bubble), 32'd0);
    chk("imem_br_pcnew", PCnew, 32'h400);
    chk("imem_br_stall_cnt", 32'(stall_cnt), 32'd2);
    step();
    br_taken = 0;
    step(); step();
    imem_ready = 1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      trap_req   = ($urandom_range(0, 19) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      jmp_valid  = ($urandom_range(0, 5) == 0);
      ld_use     = ($urandom_range(0, 4) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      pc_in      = $urandom;
      br_target  = $urandom;
      jmp_target = $urandom;
      step();
    end

    // Saturation: reset, then 65534 + 3 bubble cycles
    rst = 0; idle_inputs(); step();
    rst = 1; imem_ready = 0;
    repeat (65534) step();
    chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    repeat (3) step();
    chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
